// File: rtl/bcd_7seg_scan_driver.sv
// Multiplexed 7-segment driver: packed BCD in via a load/pending/ack path, one digit
// per refresh slot, with leading-zero blanking, invalid-digit flag and pin polarity.
module bcd_7seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter bit COMMON_ANODE = 1'b0,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  load_ack,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  bcd_err
);

  localparam int TICK_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_bcd_q, disp_bcd_d, pend_bcd_q, pend_bcd_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic                load_ack_q, load_ack_d;
  logic                bcd_err_q, bcd_err_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                boundary, apply;
  logic [3:0]          digit [DIGITS];
  logic [DIGITS-1:0]   blank, pend_bad;
  logic [3:0]          cur_digit;
  logic [6:0]          seg_raw;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Digit k is a leading zero when it and every digit above it are zero; digit 0 always shows.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit[gi]    = disp_bcd_q[4*gi +: 4];
      assign pend_bad[gi] = pend_bcd_q[4*gi+3] & (pend_bcd_q[4*gi+2] | pend_bcd_q[4*gi+1]);
      if (gi == 0) begin : g_lsd
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = LZ_BLANK & ~(|disp_bcd_q[4*DIGITS-1:4*gi]);
      end
    end
  endgenerate

  assign boundary = (tick_q == TICK_LAST);
  assign apply    = boundary & pend_valid_q;

  always_comb begin
    tick_d       = boundary ? '0 : tick_q + 1'b1;
    idx_d        = idx_q;
    pend_bcd_d   = pend_bcd_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_bcd_d   = disp_bcd_q;
    disp_dp_d    = disp_dp_q;
    bcd_err_d    = bcd_err_q;
    load_ack_d   = apply;
    if (boundary) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (apply) begin
      disp_bcd_d   = pend_bcd_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
      bcd_err_d    = |pend_bad;
    end
    // A load on the boundary lands in pending after the old pending value is applied.
    if (load) begin
      pend_bcd_d   = bcd_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    cur_digit = digit[idx_q];
    seg_raw   = blank[idx_q] ? 7'b0000000 : decode(cur_digit);
    seg_d     = seg_raw ^ {7{COMMON_ANODE}};
    dp_d      = disp_dp_q[idx_q] ^ COMMON_ANODE;
    an_d      = '0;
    for (int k = 0; k < DIGITS; k++) begin
      an_d[k] = (idx_q == IDX_W'(k)) ^ COMMON_ANODE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q       <= '0;
      idx_q        <= '0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      load_ack_q   <= 1'b0;
      bcd_err_q    <= 1'b0;
      seg_q        <= {7{COMMON_ANODE}};
      dp_q         <= COMMON_ANODE;
      an_q         <= {DIGITS{COMMON_ANODE}};
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_dp_q    <= disp_dp_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      load_ack_q   <= load_ack_d;
      bcd_err_q    <= bcd_err_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign load_ack = load_ack_q;
  assign bcd_err  = bcd_err_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign an       = an_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Bench for bcd_7seg_scan_driver: three parameterisations driven in lockstep and
// compared every cycle against a slot-arithmetic reference model.
module tb_bcd_7seg_scan_driver;
  localparam int D  = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;

  // Instance 0: CA=0 LZ=1, instance 1: CA=0 LZ=0, instance 2: CA=1 LZ=1
  logic       ack_w [3];
  logic [6:0] seg_w [3];
  logic       dp_w  [3];
  logic [3:0] an_w  [3];
  logic       err_w [3];

  bcd_7seg_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .COMMON_ANODE(1'b0), .LZ_BLANK(1'b1)) u_base (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .load_ack(ack_w[0]), .seg(seg_w[0]), .dp(dp_w[0]), .an(an_w[0]), .bcd_err(err_w[0]));
  bcd_7seg_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .COMMON_ANODE(1'b0), .LZ_BLANK(1'b0)) u_nolz (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .load_ack(ack_w[1]), .seg(seg_w[1]), .dp(dp_w[1]), .an(an_w[1]), .bcd_err(err_w[1]));
  bcd_7seg_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .COMMON_ANODE(1'b1), .LZ_BLANK(1'b1)) u_ca (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .load_ack(ack_w[2]), .seg(seg_w[2]), .dp(dp_w[2]), .an(an_w[2]), .bcd_err(err_w[2]));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
                               7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

  // Reference state: n = clock edges since reset release; slot = n / RD, digit = slot % D.
  int          n = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_ddp = '0, m_pdp = '0;
  bit          m_pv = 0, m_err = 0, e_ack = 0;
  logic [6:0]  e_seg [3];
  logic        e_dp  [3];
  logic [3:0]  e_an  [3];

  function automatic bit ca_of(input int c);
    return c == 2;
  endfunction

  function automatic bit lz_of(input int c);
    return c != 1;
  endfunction

  function automatic bit has_bad(input logic [15:0] v);
    for (int k = 0; k < D; k++) if (((v >> (4*k)) & 16'hF) > 9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int idx, dig;
    bit bnd, blank, ca;
    logic [6:0] s;
    if (rst) begin
      n = 0; m_disp = '0; m_ddp = '0; m_pv = 0; m_err = 0; e_ack = 0;
      for (int c = 0; c < 3; c++) begin
        ca = ca_of(c);
        e_seg[c] = {7{ca}}; e_dp[c] = ca; e_an[c] = {4{ca}};
      end
    end else begin
      idx = (n / RD) % D;
      bnd = (n % RD) == RD - 1;
      for (int c = 0; c < 3; c++) begin
        ca    = ca_of(c);
        dig   = int'((m_disp >> (4*idx)) & 16'hF);
        blank = lz_of(c) && idx != 0 && (m_disp >> (4*idx)) == 0;
        s     = blank ? 7'b0000000 : seg_tab[dig];
        e_seg[c] = s ^ {7{ca}};
        e_dp[c]  = m_ddp[idx] ^ ca;
        e_an[c]  = (4'b0001 << idx) ^ {4{ca}};
      end
      e_ack = bnd && m_pv;
      if (bnd && m_pv) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pv = 0; m_err = has_bad(m_disp);
      end
      if (load) begin
        m_pend = bcd_in; m_pdp = dp_in; m_pv = 1;
      end
      n++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("seg%0d", c), 32'(seg_w[c]), 32'(e_seg[c]));
      chk($sformatf("dp%0d", c),  32'(dp_w[c]),  32'(e_dp[c]));
      chk($sformatf("an%0d", c),  32'(an_w[c]),  32'(e_an[c]));
      chk($sformatf("ack%0d", c), 32'(ack_w[c]), 32'(e_ack));
      chk($sformatf("err%0d", c), 32'(err_w[c]), 32'(m_err));
    end
    ack_seen += int'(ack_w[0]);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; bcd_in = v; dp_in = d;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b1;
    run(3);
    chk("rst_seg", 32'(seg_w[0]), 32'h0);
    chk("rst_an_ca", 32'(an_w[2]), 32'hF);
    rst = 1'b0;
    cycle();
    chk("rel_an", 32'(an_w[0]), 32'h1);
    chk("rel_seg", 32'(seg_w[0]), 32'h7E);

    do_load(16'h1234, 4'b0100); run(24);
    do_load(16'h0047, 4'b0000); run(20);
    do_load(16'h0000, 4'b0000); run(20);
    do_load(16'h12A4, 4'b0000); run(12);
    chk("err_set", 32'(err_w[0]), 32'h1);
    do_load(16'h1234, 4'b1000); run(12);
    chk("err_clr", 32'(err_w[0]), 32'h0);

    // Two loads inside one slot give a single acknowledge
    while (n % RD != 0) cycle();
    ack_seen = 0;
    do_load(16'h1111, 4'b0001); cycle();
    do_load(16'h2222, 4'b0010); run(2*RD);
    chk("one_ack", 32'(ack_seen), 32'd1);

    // Load on the boundary cycle is applied one slot later
    while (n % RD != RD - 1) cycle();
    ack_seen = 0;
    do_load(16'h5678, 4'b0011); run(RD - 1);
    chk("bnd_noack", 32'(ack_seen), 32'd0);
    cycle();
    chk("bnd_ack", 32'(ack_seen), 32'd1);

    // Reset at idx=2 with a load pending drops it silently
    while (!((n % RD == 0) && ((n / RD) % D == 2))) cycle();
    do_load(16'h9999, 4'b1111);
    ack_seen = 0;
    rst = 1'b1; cycle(); rst = 1'b0;
    run(3*RD);
    chk("rst_noack", 32'(ack_seen), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < D; k++) v[4*k +: 4] = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 2) == 0) v = v >> (4 * $urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) v = '0;
      bcd_in = v;
      dp_in  = 4'($urandom);
      cycle();
    end
    rst = 1'b0; load = 1'b0;
    run(2*RD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
